// File: rtl/calc_pkg.sv
// Shared definitions for the 32-bit calculator datapaths and their sequencer.
package calc_pkg;

  // Native operand width of the calculator.
  localparam int CALC_WIDTH = 32;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Quotient reported when dividing by zero.
  localparam logic [CALC_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  // Operation select codes used by the sequencer to pick a functional unit.
  typedef logic [1:0] calc_op_t;
  localparam calc_op_t OP_ADD = 2'd0;
  localparam calc_op_t OP_SUB = 2'd1;
  localparam calc_op_t OP_MUL = 2'd2;
  localparam calc_op_t OP_DIV = 2'd3;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_step
  import calc_pkg::*;
#(
  parameter int N = CALC_WIDTH
) (
  input  logic [N-1:0] r_i,        // partial remainder, always < divisor
  input  logic [N-1:0] q_i,        // remaining dividend bits / quotient so far
  input  logic [N-1:0] divisor_i,
  output logic [N-1:0] r_o,
  output logic [N-1:0] q_o
);

  logic [N:0] t;
  logic [N:0] d;

  // The trial subtraction is N+1 bits wide so the shifted remainder T, which
  // can reach 2**(N+1)-1 in width terms, is compared exactly; the borrow lands
  // in d[N]. Whichever value is kept is below the divisor, so N bits suffice.
  always_comb begin
    t = {r_i, q_i[N-1]};
    d = t - {1'b0, divisor_i};
    if (!d[N]) begin
      r_o = d[N-1:0];
      q_o = {q_i[N-2:0], 1'b1};
    end else begin
      r_o = t[N-1:0];
      q_o = {q_i[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/done handshake. Results are held until the next accepted start.
//
// state | meaning
// IDLE  | waiting for start; results of the last operation held
// CALC  | iterating, one quotient bit per cycle (busy)
// DONE  | one-cycle done pulse; a new start may be accepted here
//
// A zero divisor also passes through CALC for a single cycle with the counter
// preloaded to its final value, so done arrives two cycles after acceptance.
module seq_divider
  import calc_pkg::*;
#(
  parameter int N  = CALC_WIDTH,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [N-1:0]  r_q,     r_d;
  logic [N-1:0]  q_q,     q_d;
  logic [N-1:0]  dvs_q,   dvs_d;
  logic          zero_q,  zero_d;
  logic [N-1:0]  quot_q,  quot_d;
  logic [N-1:0]  rem_q,   rem_d;
  logic          dbz_q,   dbz_d;

  logic [N-1:0]  step_r;
  logic [N-1:0]  step_q;
  logic          load;

  div_step #(.N(N)) u_step (
    .r_i       (r_q),
    .q_i       (q_q),
    .divisor_i (dvs_q),
    .r_o       (step_r),
    .q_o       (step_q)
  );

  // State, counter, datapath and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state, iteration and result-capture logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        load = start;
      end
      CALC: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          if (zero_q) begin
            // Q still holds the untouched dividend on the single zero pass.
            quot_d = '1;
            rem_d  = q_q;
            dbz_d  = 1'b1;
          end else begin
            quot_d = step_q;
            rem_d  = step_r;
            dbz_d  = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        load    = start;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      state_d = CALC;
      dvs_d   = divisor;
      q_d     = dividend;
      r_d     = '0;
      zero_d  = (divisor == '0);
      cnt_d   = (divisor == '0) ? LAST_CNT : '0;
    end
  end

  assign busy        = (state_q == CALC);
  assign ready       = !busy;
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider: result values, latency,
// handshake behaviour and reset during an operation.
module tb_seq_divider;

  localparam int N  = 32;
  localparam int CW = 6;
  localparam int TIMEOUT = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_divider #(.N(N), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [N-1:0] dvd;
    logic [N-1:0] dvs;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present an operation, release start after the accepting edge and count
  // edges (acceptance edge included) until done is observed.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic [N-1:0] q, output logic [N-1:0] r,
                        output logic z, output int lat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    while (!done && lat < TIMEOUT) begin
      @(posedge clk);
      lat++;
      #1;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  initial begin
    logic [N-1:0] q, r, a, b, prev_q, prev_r;
    logic         z, held_ok, seen_done;
    int           lat;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 64'(ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset quotient", 64'(quotient), 64'd0);
    chk("reset remainder", 64'(remainder), 64'd0);
    chk("reset dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    vecs[0] = '{32'd75,         32'd25,         32'd3,          32'd0,    1'b0, 33};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,    1'b0, 33};
    vecs[2] = '{32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5,    1'b0, 33};
    vecs[3] = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234, 1'b1, 2};
    vecs[4] = '{32'd100,        32'd7,          32'd14,         32'd2,    1'b0, 33};
    vecs[5] = '{32'd0,          32'd5,          32'd0,          32'd0,    1'b0, 33};
    vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,    1'b0, 33};
    vecs[7] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,    1'b0, 33};
    vecs[8] = '{32'd1000,       32'd10,         32'd100,        32'd0,    1'b0, 33};
    vecs[9] = '{32'd7,          32'd100,        32'd0,          32'd7,    1'b0, 33};

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, q, r, z, lat);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d quotient", i), 64'(q), 64'(vecs[i].q));
      chk($sformatf("vec%0d remainder", i), 64'(r), 64'(vecs[i].r));
      chk($sformatf("vec%0d dbz", i), 64'(z), 64'(vecs[i].dbz));
      chk($sformatf("vec%0d ready at done", i), 64'(ready), 64'd1);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d done pulse width", i), 64'(done), 64'd0);
      chk($sformatf("vec%0d result held", i), 64'(quotient), 64'(vecs[i].q));
    end
    prev_q = quotient;
    prev_r = remainder;

    // start held high throughout CALC with different operands: ignored, and
    // still high in the DONE cycle with 9/4 gives a back-to-back operation.
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    dividend = 32'd9;
    divisor  = 32'd4;
    held_ok  = 1'b1;
    while (!done && lat < TIMEOUT) begin
      if (quotient !== prev_q || remainder !== prev_r || busy !== 1'b1) held_ok = 1'b0;
      @(posedge clk);
      lat++;
      #1;
    end
    chk("held start: results stable during calc", 64'(held_ok), 64'd1);
    chk("held start: latency", 64'(lat), 64'd33);
    chk("held start: quotient", 64'(quotient), 64'd14);
    chk("held start: remainder", 64'(remainder), 64'd2);
    @(posedge clk);
    lat = 1;
    #1;
    start   = 1'b0;
    chk("back-to-back: busy after DONE start", 64'(busy), 64'd1);
    held_ok = 1'b1;
    while (!done && lat < TIMEOUT) begin
      if (quotient !== 32'd14 || remainder !== 32'd2) held_ok = 1'b0;
      @(posedge clk);
      lat++;
      #1;
    end
    chk("back-to-back: results stable during calc", 64'(held_ok), 64'd1);
    chk("back-to-back: latency", 64'(lat), 64'd33);
    chk("back-to-back: quotient", 64'(quotient), 64'd2);
    chk("back-to-back: remainder", 64'(remainder), 64'd1);
    @(posedge clk);
    #1;

    // Reset asserted in the middle of an operation.
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid-calc reset: ready", 64'(ready), 64'd1);
    chk("mid-calc reset: busy", 64'(busy), 64'd0);
    chk("mid-calc reset: done", 64'(done), 64'd0);
    chk("mid-calc reset: quotient", 64'(quotient), 64'd0);
    chk("mid-calc reset: remainder", 64'(remainder), 64'd0);
    chk("mid-calc reset: dbz", 64'(div_by_zero), 64'd0);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    chk("mid-calc reset: no done pulse", 64'(seen_done), 64'd0);
    run_op(32'd100, 32'd7, q, r, z, lat);
    chk("after reset: latency", 64'(lat), 64'd33);
    chk("after reset: quotient", 64'(q), 64'd14);
    chk("after reset: remainder", 64'(r), 64'd2);
    @(posedge clk);
    #1;

    // Random operands against the division invariants.
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == '0) b = 32'd1;
      run_op(a, b, q, r, z, lat);
      chk($sformatf("rand%0d done seen", i), 64'(lat < TIMEOUT), 64'd1);
      chk($sformatf("rand%0d q*d+r", i), 64'(q) * 64'(b) + 64'(r), 64'(a));
      chk($sformatf("rand%0d r<d", i), 64'(r < b), 64'd1);
      chk($sformatf("rand%0d dbz", i), 64'(z), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
